// File: rtl/tape_fifo_player_pkg.sv
// Shared types and constants for the tape FIFO player: state encoding,
// counter widths and the default 50 MHz half-pulse lengths.
package tape_player_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PILOT,
    SYNC1,
    SYNC2,
    FETCH,
    FETCH_WAIT,
    DATA,
    UNDERRUN
  } state_t;

  localparam int LEN_W  = 16;
  localparam int GAP_W  = 26;
  localparam int PCNT_W = 12;

  localparam int DEF_PILOT_HALF  = 30971;
  localparam int DEF_PILOT_COUNT = 3223;
  localparam int DEF_SYNC1_HALF  = 9529;
  localparam int DEF_SYNC2_HALF  = 10500;
  localparam int DEF_ZERO_HALF   = 12214;
  localparam int DEF_ONE_HALF    = 24429;
  localparam int DEF_GAP_CYCLES  = 50000000;

endpackage

// File: rtl/tape_fifo_player_if.sv
// Read side of the hyperload tape FIFO: pop strobe out, data and empty flag in.
interface tape_fifo_if;
  logic [7:0] fifo_q;
  logic       fifo_empty;
  logic       fifo_rd;

  modport master (output fifo_rd, input fifo_q, input fifo_empty);
  modport slave  (input fifo_rd, output fifo_q, output fifo_empty);
endinterface

// File: rtl/tape_fifo_player_half_timer.sv
// Half-pulse down-counter: load LEN, count while enabled, expire in the last cycle
// so a reload on expiry gives exactly LEN cycles between toggles.
module tape_half_timer
  import tape_player_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  output logic             expire
);

  logic [LEN_W-1:0] count;

  assign expire = enable && !clear && (count == LEN_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (load)
        count <= len;
      else if (count != '0)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/tape_fifo_player.sv
// Tape FIFO consumer: pops raw bytes and regenerates a ROM-loader EAR waveform
// (pilot, sync, MSB-first data). Optional TAPE_PLAYER_TURBO_EN adds a turbo port.
module tape_fifo_player
  import tape_player_pkg::*;
#(
  parameter int PILOT_HALF  = DEF_PILOT_HALF,
  parameter int PILOT_COUNT = DEF_PILOT_COUNT,
  parameter int SYNC1_HALF  = DEF_SYNC1_HALF,
  parameter int SYNC2_HALF  = DEF_SYNC2_HALF,
  parameter int ZERO_HALF   = DEF_ZERO_HALF,
  parameter int ONE_HALF    = DEF_ONE_HALF,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        flush,
`ifdef TAPE_PLAYER_TURBO_EN
  input  logic        turbo,
`endif
  tape_fifo_if.master fifo,
  output logic        ear_out,
  output logic        busy,
  output logic [15:0] byte_count
);

  state_t            state, state_next;
  logic              ear, ear_next;
  logic [7:0]        shift, shift_next;
  logic [2:0]        bit_idx, bit_idx_next;
  logic              second, second_next;
  logic [PCNT_W-1:0] pilot_cnt, pilot_next;
  logic [GAP_W-1:0]  gap, gap_next;
  logic [15:0]       played, played_next;
  logic              rd;
  logic              tmr_load;
  logic [LEN_W-1:0]  tmr_len;
  logic              expire;
  logic              turbo_on;

`ifdef TAPE_PLAYER_TURBO_EN
  assign turbo_on = turbo;
`else
  assign turbo_on = 1'b0;
`endif

  function automatic logic [LEN_W-1:0] half_len(input int len, input logic halve);
    return halve ? LEN_W'(len >> 1) : LEN_W'(len);
  endfunction

  function automatic logic [LEN_W-1:0] bit_len(input logic b, input logic halve);
    return half_len(b ? ONE_HALF : ZERO_HALF, halve);
  endfunction

  tape_half_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .enable  (enable),
    .load    (tmr_load),
    .len     (tmr_len),
    .expire  (expire)
  );

  always_comb begin
    state_next   = state;
    ear_next     = ear;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    second_next  = second;
    pilot_next   = pilot_cnt;
    gap_next     = gap;
    played_next  = played;
    rd           = 1'b0;
    tmr_load     = 1'b0;
    tmr_len      = '0;

    if (flush) begin
      state_next   = IDLE;
      ear_next     = 1'b0;
      shift_next   = '0;
      bit_idx_next = '0;
      second_next  = 1'b0;
      pilot_next   = '0;
      gap_next     = '0;
      played_next  = '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (!fifo.fifo_empty) begin
            state_next = PILOT;
            pilot_next = '0;
            tmr_load   = 1'b1;
            tmr_len    = half_len(PILOT_HALF, turbo_on);
          end
        end
        PILOT: begin
          if (expire) begin
            ear_next = ~ear;
            tmr_load = 1'b1;
            if (pilot_cnt == PCNT_W'(PILOT_COUNT - 1)) begin
              state_next = SYNC1;
              tmr_len    = half_len(SYNC1_HALF, turbo_on);
            end else begin
              pilot_next = pilot_cnt + 1'b1;
              tmr_len    = half_len(PILOT_HALF, turbo_on);
            end
          end
        end
        SYNC1: begin
          if (expire) begin
            ear_next   = ~ear;
            state_next = SYNC2;
            tmr_load   = 1'b1;
            tmr_len    = half_len(SYNC2_HALF, turbo_on);
          end
        end
        SYNC2: begin
          if (expire) begin
            ear_next   = ~ear;
            state_next = FETCH;
          end
        end
        FETCH: begin
          if (fifo.fifo_empty) begin
            state_next = UNDERRUN;
            gap_next   = '0;
          end else begin
            rd         = 1'b1;
            state_next = FETCH_WAIT;
          end
        end
        // Popped byte is on fifo_q now; the first data half starts here, two cycles
        // after the previous toggle, and that latency is deliberately left in.
        FETCH_WAIT: begin
          shift_next   = fifo.fifo_q;
          bit_idx_next = 3'd7;
          second_next  = 1'b0;
          played_next  = played + 1'b1;
          state_next   = DATA;
          tmr_load     = 1'b1;
          tmr_len      = bit_len(fifo.fifo_q[7], turbo_on);
        end
        DATA: begin
          if (expire) begin
            ear_next = ~ear;
            tmr_load = 1'b1;
            if (!second) begin
              second_next = 1'b1;
              tmr_len     = bit_len(shift[7], turbo_on);
            end else begin
              second_next = 1'b0;
              shift_next  = {shift[6:0], 1'b0};
              if (bit_idx == 3'd0) begin
                state_next = FETCH;
                tmr_load   = 1'b0;
              end else begin
                bit_idx_next = bit_idx - 1'b1;
                tmr_len      = bit_len(shift[6], turbo_on);
              end
            end
          end
        end
        UNDERRUN: begin
          gap_next = gap + 1'b1;
          if (!fifo.fifo_empty)
            state_next = FETCH;
          else if (gap == GAP_W'(GAP_CYCLES - 1))
            state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ear       <= 1'b0;
      shift     <= '0;
      bit_idx   <= '0;
      second    <= 1'b0;
      pilot_cnt <= '0;
      gap       <= '0;
      played    <= '0;
    end else begin
      state     <= state_next;
      ear       <= ear_next;
      shift     <= shift_next;
      bit_idx   <= bit_idx_next;
      second    <= second_next;
      pilot_cnt <= pilot_next;
      gap       <= gap_next;
      played    <= played_next;
    end
  end

  assign fifo.fifo_rd = rd;
  assign ear_out      = ear;
  assign busy         = (state != IDLE);
  assign byte_count   = played;

endmodule
